// File: rtl/uart_tx_frame.sv
// uart_tx_frame: parametrised UART transmitter with a one-entry holding register; optional parity via UART_TX_PARITY_EN
module uart_tx_frame #(
  parameter int CLKS_PER_BIT = 1042,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 i_Clock,
  input  logic                 i_rst,
  input  logic                 i_Tx_DV,
  input  logic [DATA_BITS-1:0] i_Tx_Byte,
  output logic                 o_Tx_Ready,
  output logic                 o_Tx_Active,
  output logic                 o_Tx_Serial,
  output logic                 o_Tx_Done
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] LAST_CLK = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
  localparam logic LAST_STOP = 1'(STOP_BITS - 1);
  if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
      PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_cfg
    $error("uart_tx_frame: illegal parameter value");
  end
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t               r_state, w_state_nxt;
  logic [CW-1:0]        r_clk_cnt, w_clk_nxt;
  logic [BW-1:0]        r_bit_idx, w_bit_nxt;
  logic                 r_stop_cnt, w_stop_nxt;
  logic [DATA_BITS-1:0] r_shift, r_hold;
  logic                 r_hold_valid, r_ready, r_serial, w_serial_nxt;
  logic                 w_load, w_accept, w_bit_end;
  assign w_accept  = i_Tx_DV && r_ready;
  assign w_bit_end = r_clk_cnt == LAST_CLK;
`ifdef UART_TX_PARITY_EN
  logic w_par;
  assign w_par = ^r_shift ^ 1'(PARITY_ODD);
`endif
  always_comb begin
    w_state_nxt  = r_state;
    w_clk_nxt    = w_bit_end ? '0 : r_clk_cnt + 1'b1;
    w_bit_nxt    = r_bit_idx;
    w_stop_nxt   = r_stop_cnt;
    w_serial_nxt = r_serial;
    w_load       = 1'b0;
    case (r_state)
      IDLE: begin
        w_clk_nxt    = '0;
        w_serial_nxt = !r_hold_valid;
        w_load       = r_hold_valid;
        w_state_nxt  = r_hold_valid ? START : IDLE;
      end
      START: if (w_bit_end) begin
        w_state_nxt  = DATA;
        w_bit_nxt    = '0;
        w_serial_nxt = r_shift[0];
      end
      DATA: if (w_bit_end) begin
        if (r_bit_idx == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
          w_state_nxt  = PARITY;
          w_serial_nxt = w_par;
`else
          w_state_nxt  = STOP;
          w_serial_nxt = 1'b1;
          w_stop_nxt   = 1'b0;
`endif
        end else begin
          w_bit_nxt    = r_bit_idx + 1'b1;
          w_serial_nxt = r_shift[w_bit_nxt];
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (w_bit_end) begin
        w_state_nxt  = STOP;
        w_serial_nxt = 1'b1;
        w_stop_nxt   = 1'b0;
      end
`endif
      STOP: if (w_bit_end) begin
        if (r_stop_cnt == LAST_STOP) begin
          // a held byte starts its frame straight out of the last stop cycle
          w_load       = r_hold_valid;
          w_serial_nxt = !r_hold_valid;
          w_state_nxt  = r_hold_valid ? START : IDLE;
        end else begin
          w_stop_nxt = r_stop_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt  = IDLE;
        w_clk_nxt    = '0;
        w_serial_nxt = 1'b1;
      end
    endcase
  end
  always_ff @(posedge i_Clock or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_clk_cnt    <= '0;
      r_bit_idx    <= '0;
      r_stop_cnt   <= 1'b0;
      r_shift      <= '0;
      r_hold       <= '0;
      r_hold_valid <= 1'b0;
      r_ready      <= 1'b1;
      r_serial     <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_clk_cnt    <= w_clk_nxt;
      r_bit_idx    <= w_bit_nxt;
      r_stop_cnt   <= w_stop_nxt;
      r_serial     <= w_serial_nxt;
      r_hold_valid <= w_accept || (r_hold_valid && !w_load);
      // ready stays low through the drain edge and reopens one edge later
      r_ready      <= !(w_accept || r_hold_valid);
      if (w_load) r_shift <= r_hold;
      if (w_accept) r_hold <= i_Tx_Byte;
    end
  end
  assign o_Tx_Ready  = r_ready;
  assign o_Tx_Serial = r_serial;
  assign o_Tx_Active = r_state inside {START, DATA, PARITY, STOP};
  assign o_Tx_Done   = (r_state == STOP) && w_bit_end && (r_stop_cnt == LAST_STOP);
endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised UART transmitter for the serial output path. It generalises the fixed 8N1 transmitter to configurable data width and stop-bit count, with an optional parity bit. A one-entry holding register lets a producer queue the next byte while the current frame is still shifting, so consecutive frames go out back-to-back with no idle gap. It sits between a byte producer (command/response logic) and the TX pin.

## Interface
- CLKS_PER_BIT, 1042, clock cycles per serial bit; legal range ≥ 2.
- DATA_BITS, 8, data bits per frame; legal range 5–9.
- STOP_BITS, 1, stop bits per frame; legal values 1 or 2.
- PARITY_ODD, 0, parity sense: 0 = even, 1 = odd. Used only with UART_TX_PARITY_EN.
- i_Clock  in  1  single clock; all logic is on its rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_Tx_DV  in  1  byte valid; accepted only while o_Tx_Ready = 1.
- i_Tx_Byte  in  DATA_BITS  byte to transmit; sampled on the accepting edge.
- o_Tx_Ready  out  1  holding register empty; registered.
- o_Tx_Active  out  1  a frame is on the line.
- o_Tx_Serial  out  1  serial line; idles high.
- o_Tx_Done  out  1  one-cycle pulse when a frame's last stop bit completes.

## Operation
- Reset values: o_Tx_Serial = 1, o_Tx_Ready = 1, o_Tx_Active = 0, o_Tx_Done = 0. State is IDLE. The holding register, shift register and both counters are cleared.
- Acceptance: i_Tx_DV && o_Tx_Ready on a rising edge.
  - The byte is written to the holding register and hold_valid is set.
  - o_Tx_Ready = !hold_valid.
  - i_Tx_DV while o_Tx_Ready = 0 is ignored and the byte is dropped. This includes the edge on which the holding register drains, because ready is registered.
- States:
  - IDLE: drive line 1. If hold_valid, load the shift register, clear hold_valid, drive line 0, set o_Tx_Active, go to START.
  - START → DATA after CLKS_PER_BIT cycles.
  - DATA: bits are sent LSB first, each for CLKS_PER_BIT cycles. After bit DATA_BITS-1, go to PARITY if enabled, else STOP.
  - PARITY: one bit time, then STOP.
  - STOP: line 1 for STOP_BITS × CLKS_PER_BIT cycles. On the final cycle pulse o_Tx_Done, then:
    - if hold_valid: load the next byte, drive line 0 and go to START; o_Tx_Active stays 1.
    - otherwise: go to IDLE and clear o_Tx_Active.
- There is no cleanup state.
- Counter widths:
  - clock counter: $clog2(CLKS_PER_BIT) bits, counts 0..CLKS_PER_BIT-1.
  - bit index: $clog2(DATA_BITS) bits.
  - stop counter: 1 bit.
- Undefined state codes recover to IDLE with line 1.
- Reset mid-frame: o_Tx_Serial goes to 1 asynchronously, the frame and any queued byte are discarded, and no o_Tx_Done is issued.

## Timing
- Acceptance edge E loads the holding register. If idle, the start bit begins at edge E+1.
- Frame length is F = CLKS_PER_BIT × (1 + DATA_BITS + P + STOP_BITS) cycles, where P = 1 with parity, else 0.
- o_Tx_Done is high exactly one cycle, on the last cycle of the last stop bit.
- Back-to-back frames: the next start bit follows the final stop cycle with zero idle cycles.
- o_Tx_Ready returns to 1 on the edge after the holding register is loaded into the shift register.
- Every serial bit is exactly CLKS_PER_BIT cycles wide.

## Configuration
- Macro: UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted after the data bits. The parity bit is the XOR of the data bits, inverted when PARITY_ODD = 1.
- Undefined: frames contain no parity bit, the PARITY state and parity logic are not built, and PARITY_ODD has no effect.

## Test plan
- CLKS_PER_BIT=4, DATA_BITS=8, STOP_BITS=1, no parity; send 0xA5 from idle. Required line bits, each 4 cycles wide: 0,1,0,1,0,0,1,0,1,1. o_Tx_Done pulses on cycle 40 of the frame; o_Tx_Active is high for cycles 1–40.
- Same setup with UART_TX_PARITY_EN:
  - 0xA5, even parity: parity bit 0, 44-cycle frame.
  - 0x07, PARITY_ODD=1: parity bit 0.
  - 0x03, PARITY_ODD=1: parity bit 1.
- Send 0x00, then 0xFF during the first frame's data bits. o_Tx_Ready drops for one byte only; the 0xFF start bit follows the final stop cycle with no idle; o_Tx_Done pulses twice; o_Tx_Active never drops between frames.
- With a byte already held and a frame in flight, assert i_Tx_DV with 0x55. It is ignored: only the two earlier bytes appear on the line.
- DATA_BITS=5, STOP_BITS=2, CLKS_PER_BIT=3; send 0x1F. Line bits: 0,1,1,1,1,1,1,1; frame is 24 cycles long; o_Tx_Done pulses on cycle 24.
- Assert i_rst asynchronously in the middle of data bit 3. o_Tx_Serial goes to 1 before the next clock edge, no o_Tx_Done is issued, o_Tx_Ready = 1, and the queued byte is lost.
